input_port_buffer: RTL and testbench



---
 rtl/input_port_buffer.sv | 166 ++++++++++++++++
 tb/tb_input_port_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-input-port flit buffer for the 6x6 router.
// It filters malformed packet framing on the write side. Accepted flits go into a
// first-word-fall-through FIFO. The head-of-queue flit is broadcast to all output
// allocators and is popped when no allocator asserts not-accept.
// DEPTH must be a power of two and at least 2, so the pointers wrap by overflow.
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 67
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] FLIT_in,
  input  logic              VALID_in,
  output logic              BWDAUX1_out,
  output logic [FLIT_W-1:0] FLIT_out,
  output logic              VALID_out,
  output logic              FWDAUX1_out,
  input  logic [5:0]        BWDAUX1_in,
  output logic [2:0]        route_out,
  output logic [7:0]        drop_cnt
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] TYPE_TAIL    = 3'b000;
  localparam logic [2:0] TYPE_PAYLOAD = 3'b010;
  localparam logic [2:0] TYPE_HEAD    = 3'b011;

  typedef enum logic {
    WAIT_HEAD = 1'b0,
    IN_PKT    = 1'b1
  } state_e;

  // Storage and state
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        route_q, route_d;
  logic [7:0]        drop_q, drop_d;
  state_e            state_q, state_d;

  // Handshake terms
  logic       full;
  logic       offer;
  logic       wr_en;
  logic       drop_en;
  logic       pop;
  logic [2:0] in_type;

  assign full    = (count_q == FULL_CNT);
  // When the FIFO is full the incoming flit is neither inspected nor consumed.
  // Upstream keeps holding it until the stall clears.
  assign offer   = VALID_in & ~full;
  assign in_type = FLIT_in[2:0];

  // Read side: the FIFO falls through, so the head entry is always visible.
  assign VALID_out   = (count_q != '0);
  assign FLIT_out    = mem_q[rd_ptr_q];
  assign FWDAUX1_out = VALID_out & (FLIT_out[2:0] == TYPE_HEAD);
  // Only the allocator targeted by this packet can assert not-accept.
  // So an OR of all six lines is enough to block the pop.
  assign pop         = VALID_out & ~|BWDAUX1_in;
  assign route_out   = FWDAUX1_out ? FLIT_out[5:3] : route_q;
  assign BWDAUX1_out = full;
  assign drop_cnt    = drop_q;

  // Framing filter: decide whether an offered flit is written, dropped or advances the packet state
  always_comb begin
    // NOTE: blocking assignments in combinational logic, and every signal gets a
    // default first so that no latch is inferred on any path.
    state_d = state_q;
    wr_en   = 1'b0;
    drop_en = 1'b0;
    if (offer) begin
      unique case (state_q)
        WAIT_HEAD: begin
          if (in_type == TYPE_HEAD) begin
            wr_en   = 1'b1;
            state_d = IN_PKT;
          end else begin
            drop_en = 1'b1;
          end
        end
        IN_PKT: begin
          if (in_type == TYPE_PAYLOAD) begin
            wr_en = 1'b1;
          end else if (in_type == TYPE_TAIL) begin
            wr_en   = 1'b1;
            state_d = WAIT_HEAD;
          end else begin
            // A stray head or an illegal code inside a packet is discarded.
            // The packet stays open and waits for its tail.
            drop_en = 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO bookkeeping: storage write, pointer advance, occupancy, route latch, drop counter
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    route_d  = route_q;
    drop_d   = drop_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = FLIT_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A write and a pop in the same cycle leave the occupancy unchanged.
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The route is kept after the head leaves. The rest of the packet then still
    // reports the destination it was granted to.
    if (pop && FWDAUX1_out) begin
      route_d = FLIT_out[5:3];
    end

    if (drop_en && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the storage array is reset too, because FLIT_out reads
      // mem[rd_ptr] even when empty and must show zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      route_q  <= '0;
      drop_q   <= '0;
      state_q  <= WAIT_HEAD;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      route_q  <= route_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer. A queue-based packet model runs
// alongside the DUT and predicts every output after each rising edge.
module tb_input_port_buffer;

  localparam int DEPTH  = 4;
  localparam int FLIT_W = 67;

  localparam logic [2:0] T_HEAD = 3'b011;
  localparam logic [2:0] T_PAY  = 3'b010;
  localparam logic [2:0] T_TAIL = 3'b000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLIT_W-1:0] FLIT_in = '0;
  logic              VALID_in = 1'b0;
  logic              BWDAUX1_out;
  logic [FLIT_W-1:0] FLIT_out;
  logic              VALID_out;
  logic              FWDAUX1_out;
  logic [5:0]        BWDAUX1_in = '0;
  logic [2:0]        route_out;
  logic [7:0]        drop_cnt;

  input_port_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .FLIT_in    (FLIT_in),
    .VALID_in   (VALID_in),
    .BWDAUX1_out(BWDAUX1_out),
    .FLIT_out   (FLIT_out),
    .VALID_out  (VALID_out),
    .FWDAUX1_out(FWDAUX1_out),
    .BWDAUX1_in (BWDAUX1_in),
    .route_out  (route_out),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [FLIT_W-1:0] q[$];   // flits held in the buffer, oldest first
  bit                m_in_pkt;
  int                m_drops;
  logic [2:0]        m_route;

  logic [FLIT_W-1:0] tx[$];  // flits the upstream link still has to deliver

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [FLIT_W-1:0] obs, input logic [FLIT_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [2:0] t, input logic [2:0] d, input logic [60:0] tag);
    return {tag, d, t};
  endfunction

  // Applies the packet rules to one clock edge
  task automatic model_step(input logic r, input logic vin, input logic [FLIT_W-1:0] f, input logic [5:0] na);
    logic [2:0] t;
    bit full, do_pop, do_wr, drop;
    if (!r) begin
      q.delete();
      m_in_pkt = 0;
      m_drops  = 0;
      m_route  = '0;
      return;
    end
    t      = f[2:0];
    full   = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && (na == 6'd0);
    do_wr  = 0;
    drop   = 0;
    if (vin && !full) begin
      if (!m_in_pkt) begin
        if (t == T_HEAD) begin do_wr = 1; m_in_pkt = 1; end
        else drop = 1;
      end else begin
        if (t == T_PAY) do_wr = 1;
        else if (t == T_TAIL) begin do_wr = 1; m_in_pkt = 0; end
        else drop = 1;
      end
    end
    if (drop && m_drops < 255) m_drops++;
    if (do_pop) begin
      if (q[0][2:0] == T_HEAD) m_route = q[0][5:3];
      void'(q.pop_front());
    end
    if (do_wr) q.push_back(f);
  endtask

  task automatic check_outputs(input string ctx);
    logic              exp_valid, exp_head;
    logic [2:0]        exp_route;
    logic [FLIT_W-1:0] exp_flit;
    exp_valid = (q.size() != 0);
    exp_flit  = exp_valid ? q[0] : '0;
    exp_head  = exp_valid && (exp_flit[2:0] == T_HEAD);
    exp_route = exp_head ? exp_flit[5:3] : m_route;
    check({ctx, ".valid"}, FLIT_W'(VALID_out), FLIT_W'(exp_valid));
    if (exp_valid) check({ctx, ".flit"}, FLIT_out, exp_flit);
    check({ctx, ".head"},  FLIT_W'(FWDAUX1_out), FLIT_W'(exp_head));
    check({ctx, ".stall"}, FLIT_W'(BWDAUX1_out), FLIT_W'(q.size() == DEPTH));
    check({ctx, ".route"}, FLIT_W'(route_out), FLIT_W'(exp_route));
    check({ctx, ".drops"}, FLIT_W'(drop_cnt), FLIT_W'(m_drops));
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare after the edge
  task automatic cycle(input logic r, input logic vin, input logic [FLIT_W-1:0] f, input logic [5:0] na, input string ctx);
    rst        = r;
    VALID_in   = vin;
    FLIT_in    = f;
    BWDAUX1_in = na;
    model_step(r, vin, f, na);
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  // Upstream link: present tx[0] until it is accepted or the cycle budget runs out
  task automatic send(input logic [5:0] na, input int max_cyc, input string ctx);
    bit acc;
    for (int c = 0; c < max_cyc && tx.size() != 0; c++) begin
      acc = (q.size() != DEPTH);
      cycle(1'b1, 1'b1, tx[0], na, ctx);
      if (acc) void'(tx.pop_front());
    end
  endtask

  task automatic drain(input int max_cyc, input string ctx);
    for (int c = 0; c < max_cyc && q.size() != 0; c++) begin
      cycle(1'b1, 1'b0, '0, 6'd0, ctx);
    end
    cycle(1'b1, 1'b0, '0, 6'd0, ctx);
  endtask

  task automatic do_reset(input string ctx);
    cycle(1'b0, 1'b1, mk(T_HEAD, 3'd7, 61'h55), 6'd0, ctx);
    cycle(1'b0, 1'b1, mk(T_HEAD, 3'd7, 61'h55), 6'd0, ctx);
  endtask

  function automatic logic [FLIT_W-1:0] rand_flit();
    logic [2:0]  t;
    int          sel;
    logic [60:0] tag;
    sel = int'($urandom_range(0, 9));
    if (sel < 3)      t = T_HEAD;
    else if (sel < 6) t = T_PAY;
    else if (sel < 8) t = T_TAIL;
    else begin
      t = 3'($urandom_range(0, 7));
      if (t == T_HEAD || t == T_PAY || t == T_TAIL) t = 3'b111;
    end
    tag = 61'({$urandom(), $urandom()});
    return mk(t, 3'($urandom_range(0, 5)), tag);
  endfunction

  logic [FLIT_W-1:0] head_flit;
  logic [5:0]        na_r;

  initial begin
    // Reset with data previously buffered and VALID_in held high
    do_reset("init");
    cycle(1'b1, 1'b1, mk(T_HEAD, 3'd1, 61'hA), 6'b000001, "prefill");
    cycle(1'b1, 1'b1, mk(T_PAY,  3'd1, 61'hB), 6'b000001, "prefill");
    do_reset("reset");
    check("reset.flit_zero", FLIT_out, '0);
    check("reset.valid", FLIT_W'(VALID_out), '0);

    // Clean packet toward port 2, never blocked
    tx.push_back(mk(T_HEAD, 3'd2, 61'h100));
    tx.push_back(mk(T_PAY,  3'd2, 61'h101));
    tx.push_back(mk(T_TAIL, 3'd2, 61'h102));
    send(6'd0, 8, "clean");
    check("clean.route", FLIT_W'(route_out), FLIT_W'(3'd2));
    drain(8, "clean.drain");

    // Backpressure: six-flit packet while allocator 2 refuses
    do_reset("bp.rst");
    head_flit = mk(T_HEAD, 3'd3, 61'h200);
    tx.push_back(head_flit);
    for (int i = 0; i < 4; i++) tx.push_back(mk(T_PAY, 3'd3, 61'(32'h201 + i)));
    tx.push_back(mk(T_TAIL, 3'd3, 61'h20F));
    send(6'b000100, 8, "bp.blocked");
    check("bp.stall", FLIT_W'(BWDAUX1_out), FLIT_W'(1'b1));
    check("bp.hold_head", FLIT_out, head_flit);
    send(6'd0, 16, "bp.release");
    drain(16, "bp.drain");

    // Framing errors: payload, illegal 101, head(5), head, tail
    do_reset("frame.rst");
    tx.push_back(mk(T_PAY,  3'd1, 61'h300));
    tx.push_back(mk(3'b101, 3'd1, 61'h301));
    tx.push_back(mk(T_HEAD, 3'd5, 61'h302));
    tx.push_back(mk(T_HEAD, 3'd4, 61'h303));
    tx.push_back(mk(T_TAIL, 3'd5, 61'h304));
    send(6'd0, 10, "frame");
    drain(8, "frame.drain");
    check("frame.drops", FLIT_W'(drop_cnt), FLIT_W'(8'd3));
    check("frame.route", FLIT_W'(route_out), FLIT_W'(3'd5));

    // Two entries buffered, then ten cycles of simultaneous write and pop across the wrap
    do_reset("wrap.rst");
    cycle(1'b1, 1'b1, mk(T_HEAD, 3'd0, 61'h400), 6'b000001, "wrap.fill");
    cycle(1'b1, 1'b1, mk(T_PAY,  3'd0, 61'h401), 6'b000001, "wrap.fill");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, mk(T_PAY, 3'd0, 61'(32'h410 + i)), 6'd0, "wrap.stream");
    end
    cycle(1'b1, 1'b1, mk(T_TAIL, 3'd0, 61'h41F), 6'd0, "wrap.tail");
    drain(8, "wrap.drain");

    // Drop counter saturation, then reset in the middle of a packet
    do_reset("sat.rst");
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b1, mk(3'b111, 3'd0, 61'(i)), 6'd0, "sat");
    end
    check("sat.drops", FLIT_W'(drop_cnt), FLIT_W'(8'd255));
    cycle(1'b1, 1'b1, mk(T_HEAD, 3'd4, 61'h500), 6'b100000, "mid.head");
    cycle(1'b1, 1'b1, mk(T_PAY,  3'd4, 61'h501), 6'b100000, "mid.pay");
    do_reset("mid.rst");
    check("mid.empty", FLIT_W'(VALID_out), '0);
    cycle(1'b1, 1'b1, mk(T_TAIL, 3'd4, 61'h502), 6'd0, "mid.tail");
    check("mid.drops", FLIT_W'(drop_cnt), FLIT_W'(8'd1));
    check("mid.still_empty", FLIT_W'(VALID_out), '0);

    // Randomized traffic with occasional resets
    do_reset("rand.rst");
    for (int i = 0; i < 600; i++) begin
      na_r = ($urandom_range(0, 3) == 0) ? (6'b000001 << $urandom_range(0, 5)) : 6'd0;
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rand_flit(), na_r, "rand");
    end
    drain(16, "rand.drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
